// File: rtl/sayac_pkg.sv
// rtl/sayac_pkg.sv - shared widths, state encoding and step helper for the counter decoder
package sayac_pkg;

   // Widths shared with the up/down step counter on the transmit side
   localparam int SAYAC_GENISLIK        = 6;
   localparam int ADIM_GENISLIK         = 3;
   localparam int VARSAYILAN_KILIT_ESIK = 3;

   // Decoder states: no previous sample, tracking, locked, sticky error
   typedef enum logic [1:0] {
      BOS     = 2'd0,
      TAKIP   = 2'd1,
      KILITLI = 2'd2,
      HATA    = 2'd3
   } durum_e;

   // Largest legal step magnitude for a given magnitude width
   function automatic int max_adim(input int miktar_genislik);
      return (1 << miktar_genislik) - 1;
   endfunction

endpackage

// File: rtl/adim_siniflandir.sv
// rtl/adim_siniflandir.sv - combinational step classifier between two counter samples
module adim_siniflandir
   import sayac_pkg::*;
#(
   parameter int GENISLIK        = SAYAC_GENISLIK,
   parameter int MIKTAR_GENISLIK = ADIM_GENISLIK
) (
   input  logic [GENISLIK-1:0]        sayac_in,
   input  logic [GENISLIK-1:0]        onceki,
   output logic                       durma,
   output logic                       gecerli,
   output logic                       gecersiz,
   output logic                       yon,
   output logic [MIKTAR_GENISLIK-1:0] miktar,
   output logic                       tasma
);

   // The largest step must stay below half the modulus so up and down never overlap
   localparam logic [GENISLIK-1:0] MAX = GENISLIK'(max_adim(MIKTAR_GENISLIK));

   logic [GENISLIK-1:0] fark;
   logic [GENISLIK-1:0] ters;
   logic                yukari;
   logic                asagi;

   // Forward distance and its modular negation; a down step is a small negated distance
   assign fark   = sayac_in - onceki;
   assign ters   = onceki - sayac_in;
   assign yukari = (fark != '0) && (fark <= MAX);
   assign asagi  = (ters != '0) && (ters <= MAX);

   // Classify the step and report direction, magnitude and boundary crossing
   always_comb begin
      durma    = (fark == '0);
      gecerli  = yukari || asagi;
      gecersiz = (fark != '0) && !yukari && !asagi;
      yon      = yukari;
      miktar   = '0;
      tasma    = 1'b0;
      if (yukari) begin
         miktar = fark[MIKTAR_GENISLIK-1:0];
         tasma  = (sayac_in < onceki);
      end else if (asagi) begin
         miktar = ters[MIKTAR_GENISLIK-1:0];
         tasma  = (sayac_in > onceki);
      end
   end

endmodule

// File: rtl/sayac_cozucu.sv
// rtl/sayac_cozucu.sv - recovers step direction/magnitude from sampled counter values and tracks lock
module sayac_cozucu
   import sayac_pkg::*;
#(
   parameter int GENISLIK        = SAYAC_GENISLIK,
   parameter int MIKTAR_GENISLIK = ADIM_GENISLIK,
   parameter int KILIT_ESIK      = VARSAYILAN_KILIT_ESIK
) (
   input  logic                       clk,
   input  logic                       sifirlama,
   input  logic [GENISLIK-1:0]        sayac_in,
   input  logic                       ornek,
   output logic                       yon,
   output logic [MIKTAR_GENISLIK-1:0] miktar,
   output logic                       gecerli,
   output logic                       durma,
   output logic                       tasma,
   output logic                       kilitli,
   output logic                       hata
);

   localparam int              SERI_W = $clog2(KILIT_ESIK + 1);
   localparam logic [SERI_W-1:0] ESIK = SERI_W'(KILIT_ESIK);

   durum_e                     durum_q, durum_d;
   logic [GENISLIK-1:0]        onceki_q, onceki_d;
   logic [SERI_W-1:0]          seri_q, seri_d;
   logic                       yon_q, yon_d;
   logic [MIKTAR_GENISLIK-1:0] miktar_q, miktar_d;
   logic                       gecerli_q, gecerli_d;
   logic                       durma_q, durma_d;
   logic                       tasma_q, tasma_d;
   logic                       hata_q, hata_d;

   logic                       c_durma;
   logic                       c_gecerli;
   logic                       c_gecersiz;
   logic                       c_yon;
   logic [MIKTAR_GENISLIK-1:0] c_miktar;
   logic                       c_tasma;

   adim_siniflandir #(
      .GENISLIK        (GENISLIK),
      .MIKTAR_GENISLIK (MIKTAR_GENISLIK)
   ) u_siniflandir (
      .sayac_in (sayac_in),
      .onceki   (onceki_q),
      .durma    (c_durma),
      .gecerli  (c_gecerli),
      .gecersiz (c_gecersiz),
      .yon      (c_yon),
      .miktar   (c_miktar),
      .tasma    (c_tasma)
   );

   // Next-state: one decision per strobe; yon_q/miktar_q double as the previous step for streak matching
   always_comb begin
      durum_d   = durum_q;
      onceki_d  = onceki_q;
      seri_d    = seri_q;
      yon_d     = yon_q;
      miktar_d  = miktar_q;
      gecerli_d = 1'b0;
      durma_d   = 1'b0;
      tasma_d   = 1'b0;
      hata_d    = hata_q;
      case (durum_q)
         BOS: begin
            if (ornek) begin
               onceki_d = sayac_in;
               durum_d  = TAKIP;
            end
         end
         TAKIP, KILITLI: begin
            if (ornek) begin
               onceki_d = sayac_in;
               if (c_durma) begin
                  durma_d = 1'b1;
                  seri_d  = '0;
                  durum_d = TAKIP;
               end else if (c_gecerli) begin
                  gecerli_d = 1'b1;
                  tasma_d   = c_tasma;
                  yon_d     = c_yon;
                  miktar_d  = c_miktar;
                  if ((c_yon == yon_q) && (c_miktar == miktar_q)) begin
                     seri_d = (seri_q >= ESIK) ? ESIK : seri_q + 1'b1;
                  end else begin
                     seri_d = SERI_W'(1);
                  end
                  durum_d = (seri_d == ESIK) ? KILITLI : TAKIP;
               end else if (c_gecersiz) begin
                  hata_d  = 1'b1;
                  durum_d = HATA;
               end
            end
         end
         default: begin
            durum_d = HATA;
         end
      endcase
   end

   // State and output registers; reset wins over a coincident strobe
   always_ff @(posedge clk) begin
      if (sifirlama) begin
         durum_q   <= BOS;
         onceki_q  <= '0;
         seri_q    <= '0;
         yon_q     <= 1'b0;
         miktar_q  <= '0;
         gecerli_q <= 1'b0;
         durma_q   <= 1'b0;
         tasma_q   <= 1'b0;
         hata_q    <= 1'b0;
      end else begin
         durum_q   <= durum_d;
         onceki_q  <= onceki_d;
         seri_q    <= seri_d;
         yon_q     <= yon_d;
         miktar_q  <= miktar_d;
         gecerli_q <= gecerli_d;
         durma_q   <= durma_d;
         tasma_q   <= tasma_d;
         hata_q    <= hata_d;
      end
   end

   assign yon     = yon_q;
   assign miktar  = miktar_q;
   assign gecerli = gecerli_q;
   assign durma   = durma_q;
   assign tasma   = tasma_q;
   assign kilitli = (durum_q == KILITLI);
   assign hata    = hata_q;

endmodule

// File: tb/tb_sayac_cozucu.sv
// tb/tb_sayac_cozucu.sv - self-checking bench for sayac_cozucu against a behavioural model
module tb_sayac_cozucu;

   localparam int MOD  = 64;
   localparam int MAXA = 7;
   localparam int K    = 3;

   logic       clk = 1'b0;
   logic       sifirlama = 1'b1;
   logic [5:0] sayac_in = '0;
   logic       ornek = 1'b0;
   logic       yon;
   logic [2:0] miktar;
   logic       gecerli;
   logic       durma;
   logic       tasma;
   logic       kilitli;
   logic       hata;

   int vektor   = 0;
   int hata_say = 0;
   bit aktif    = 0;

   // model state
   bit m_var = 0, m_hata = 0, m_kilit = 0;
   bit m_gec = 0, m_dur = 0, m_tas = 0;
   int m_prev = 0, m_seri = 0, m_yon = 0, m_miktar = 0;
   int s, d, mag;
   bit up;

   sayac_cozucu dut (
      .clk       (clk),
      .sifirlama (sifirlama),
      .sayac_in  (sayac_in),
      .ornek     (ornek),
      .yon       (yon),
      .miktar    (miktar),
      .gecerli   (gecerli),
      .durma     (durma),
      .tasma     (tasma),
      .kilitli   (kilitli),
      .hata      (hata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] bek);
      vektor++;
      if (act !== bek) begin
         hata_say++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", ad, act, bek, $time);
      end
   endtask

   // behavioural model: distance modulo 64, small forward = up, small backward = down
   always @(posedge clk) begin
      m_gec = 0; m_dur = 0; m_tas = 0;
      if (sifirlama) begin
         m_var = 0; m_hata = 0; m_kilit = 0; m_prev = 0;
         m_seri = 0; m_yon = 0; m_miktar = 0;
      end else if (ornek && !m_hata) begin
         s = int'(sayac_in);
         if (!m_var) begin
            m_var = 1;
         end else begin
            d = ((s - m_prev) % MOD + MOD) % MOD;
            if (d == 0) begin
               m_dur = 1; m_seri = 0; m_kilit = 0;
            end else if (d <= MAXA || d >= MOD - MAXA) begin
               up  = (d <= MAXA);
               mag = up ? d : MOD - d;
               m_tas = up ? (m_prev + mag > MOD - 1) : (m_prev - mag < 0);
               if ((up ? 1 : 0) == m_yon && mag == m_miktar)
                  m_seri = (m_seri + 1 > K) ? K : m_seri + 1;
               else
                  m_seri = 1;
               m_gec = 1; m_yon = up ? 1 : 0; m_miktar = mag;
               m_kilit = (m_seri == K);
            end else begin
               m_hata = 1; m_kilit = 0;
            end
         end
         m_prev = s;
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (aktif) begin
         chk("gecerli", gecerli, m_gec);
         chk("durma", durma, m_dur);
         chk("tasma", tasma, m_tas);
         chk("yon", yon, m_yon);
         chk("miktar", miktar, m_miktar);
         chk("kilitli", kilitli, m_kilit);
         chk("hata", hata, m_hata);
      end
   end

   task automatic ornekle(input int v);
      sayac_in = 6'(v);
      ornek = 1'b1;
      @(posedge clk); #1;
      ornek = 1'b0;
   endtask

   task automatic sifirla();
      sifirlama = 1'b1;
      ornek = 1'b0;
      @(posedge clk); #1;
      sifirlama = 1'b0;
   endtask

   int cur, adim;

   initial begin
      @(posedge clk); #1;
      aktif = 1;
      sifirlama = 1'b0;

      // reset state
      chk("rst_gecerli", gecerli, 0);
      chk("rst_kilitli", kilitli, 0);
      chk("rst_hata", hata, 0);
      chk("rst_miktar", miktar, 0);

      // lock on +3 steps
      ornekle(0);  chk("up_first_nopulse", gecerli, 0);
      ornekle(3);  chk("up_gecerli", gecerli, 1); chk("up_yon", yon, 1); chk("up_miktar", miktar, 3);
      ornekle(6);  chk("up_notlocked", kilitli, 0);
      ornekle(9);  chk("up_locked", kilitli, 1);
      ornekle(12); chk("up_gecerli4", gecerli, 1); chk("up_still_locked", kilitli, 1);

      // down with wrap
      sifirla();
      ornekle(2);
      ornekle(61); chk("dn_yon", yon, 0); chk("dn_miktar", miktar, 5); chk("dn_tasma1", tasma, 1);
      ornekle(56); chk("dn_miktar2", miktar, 5); chk("dn_tasma0", tasma, 0); chk("dn_gecerli", gecerli, 1);

      // up wrap
      sifirla();
      ornekle(60);
      ornekle(3);  chk("upw_yon", yon, 1); chk("upw_miktar", miktar, 7); chk("upw_tasma", tasma, 1);

      // stall breaks lock, then relock
      sifirla();
      ornekle(14); ornekle(16); ornekle(18); ornekle(20);
      chk("st_locked", kilitli, 1);
      ornekle(20);
      chk("st_durma", durma, 1); chk("st_unlock", kilitli, 0);
      chk("st_yon_hold", yon, 1); chk("st_miktar_hold", miktar, 2);
      ornekle(22); chk("st_relock1", kilitli, 0);
      ornekle(24); chk("st_relock2", kilitli, 0);
      ornekle(26); chk("st_relock3", kilitli, 1);

      // illegal jump
      sifirla();
      ornekle(10);
      ornekle(30); chk("il_hata", hata, 1); chk("il_nogec", gecerli, 0);
      ornekle(31); chk("il_ignored_gec", gecerli, 0); chk("il_sticky", hata, 1);
      ornekle(31); chk("il_ignored_dur", durma, 0);
      sifirla();   chk("il_cleared", hata, 0);
      ornekle(5);  chk("il_first_nopulse", gecerli, 0);

      // reset colliding with a strobe
      sayac_in = 6'd33; ornek = 1'b1; sifirlama = 1'b1;
      @(posedge clk); #1;
      ornek = 1'b0; sifirlama = 1'b0;
      chk("col_gecerli", gecerli, 0); chk("col_yon", yon, 0); chk("col_miktar", miktar, 0);
      ornekle(40); chk("col_bos_nopulse", gecerli, 0);
      ornekle(41); chk("col_step", miktar, 1);

      // randomized traffic
      sifirla();
      cur = 0; adim = 2;
      for (int i = 0; i < 4000; i++) begin
         sifirlama = ($urandom_range(0, 249) == 0);
         ornek = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) == 0) adim = int'($urandom_range(0, 14)) - 7;
         if ($urandom_range(0, 299) == 0) cur = cur + int'($urandom_range(8, 56));
         else cur = cur + adim;
         cur = ((cur % MOD) + MOD) % MOD;
         sayac_in = 6'(cur);
         @(posedge clk); #1;
      end
      sifirlama = 1'b0; ornek = 1'b0;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vektor, hata_say);
      $finish;
   end

endmodule
